// File: rtl/posicionador_frota.sv
//==============================================================================
// posicionador_frota
//------------------------------------------------------------------------------
// Parametrised fleet-placement controller for Batalha Naval. The controller
// walks every player through each piece in the fixed type order. The player
// uses the enter and select buttons to pick direction, orientation, X and Y.
// The controller then bounds-checks the piece, combines the result with the
// board conflict flag, and strobes a store to the board memory.
//
// Optional feature macro: AUTO_POS_EN. When this macro is defined, the last
// player places its pieces from the rnd_* inputs while mode=1.
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module posicionador_frota #(
    parameter int                    COORD_W  = 3,
    parameter int                    N_TIPOS  = 5,
    parameter logic [4*N_TIPOS-1:0]  QTD_TIPO = 20'h11225,
    parameter logic [4*N_TIPOS-1:0]  LEN_TIPO = 20'h54321,
    parameter int                    N_JOG    = 2,
    localparam int                   TIPO_W   = (N_TIPOS > 1) ? $clog2(N_TIPOS) : 1,
    localparam int                   JOG_W    = (N_JOG > 1) ? $clog2(N_JOG) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               enter,
    input  logic               select,
    input  logic               mode,
    input  logic               conflito,
`ifdef AUTO_POS_EN
    input  logic [COORD_W-1:0] rnd_x,
    input  logic [COORD_W-1:0] rnd_y,
    input  logic               rnd_dir,
`endif
    output logic [TIPO_W-1:0]  tipo,
    output logic [JOG_W-1:0]   jogador,
    output logic [COORD_W-1:0] X1,
    output logic [COORD_W-1:0] Y1,
    output logic               direcao,
    output logic               orientacao,
    output logic               valida,
    output logic               grava,
    output logic               ready
);

    // Extract nibble idx from a packed per-type table.
    function automatic logic [3:0] f_nibble(input logic [4*N_TIPOS-1:0] vec, input int idx);
        logic [4*N_TIPOS-1:0] sh;
        sh = vec >> (4 * idx);
        return sh[3:0];
    endfunction

    // First type with a nonzero count. Each player starts here after the wrap.
    function automatic int f_primeiro_tipo();
        int r;
        r = 0;
        for (int t = N_TIPOS - 1; t >= 0; t--) begin
            if (f_nibble(QTD_TIPO, t) != 4'd0) r = t;
        end
        return r;
    endfunction

    localparam int                c_EXT_W         = COORD_W + 4;
    localparam logic [TIPO_W-1:0] c_PRIMEIRO_TIPO = TIPO_W'(f_primeiro_tipo());
    localparam logic [JOG_W-1:0]  c_ULTIMO_JOG    = JOG_W'(N_JOG - 1);
    localparam logic [c_EXT_W-1:0] c_LADO         = c_EXT_W'(1) << COORD_W;

    typedef enum logic [2:0] {
        S_DIRECAO    = 3'd0,
        S_ORIENTACAO = 3'd1,
        S_DEF_X      = 3'd2,
        S_DEF_Y      = 3'd3,
        S_VERIFICA   = 3'd4,
        S_ARMAZENA   = 3'd5,
        S_FIM        = 3'd6
    } estado_t;

    estado_t             estado_q;
    logic [2:0]          enter_sync_q;
    logic [2:0]          select_sync_q;
    logic [TIPO_W-1:0]   tipo_q,    tipo_d;
    logic [JOG_W-1:0]    jogador_q, jogador_d;
    logic [3:0]          peca_q,    peca_d;
    logic                fim_d;
    logic [COORD_W-1:0]  x1_q, y1_q;
    logic                direcao_q, orientacao_q;
    logic                valida_q, valida_d;
    logic                grava_q, ready_q;
    logic                w_ent, w_sel;
    logic                w_dentro;
    logic [c_EXT_W-1:0]  w_coord, w_len;
    logic                w_prox_achado;
    logic [TIPO_W-1:0]   w_prox_tipo;

`ifndef AUTO_POS_EN
    logic                w_mode_unused;
    assign w_mode_unused = mode;
`endif

    // Button synchronisers: two stages plus an edge register. The flops idle at 1 (released).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_sync_q  <= 3'b111;
            select_sync_q <= 3'b111;
        end else begin
            enter_sync_q  <= {enter_sync_q[1:0],  enter};
            select_sync_q <= {select_sync_q[1:0], select};
        end
    end

    // A falling edge after synchronisation produces one press pulse. Enter has priority.
    assign w_ent = enter_sync_q[2] & ~enter_sync_q[1];
    assign w_sel = select_sync_q[2] & ~select_sync_q[1] & ~w_ent;

    // Bounds check at widened width so that the coordinate sum never wraps.
    always_comb begin
        w_coord  = direcao_q ? c_EXT_W'(y1_q) : c_EXT_W'(x1_q);
        w_len    = c_EXT_W'(f_nibble(LEN_TIPO, int'(tipo_q)));
        if (orientacao_q)
            w_dentro = (w_coord + c_EXT_W'(1)) >= w_len;
        else
            w_dentro = (w_coord + w_len) <= c_LADO;
        valida_d = ~conflito & w_dentro;
    end

    // Next piece: the same type, then the next type with a nonzero count, then the next player.
    always_comb begin
        w_prox_achado = 1'b0;
        w_prox_tipo   = tipo_q;
        for (int t = N_TIPOS - 1; t >= 0; t--) begin
            if (t > int'(tipo_q) && f_nibble(QTD_TIPO, t) != 4'd0) begin
                w_prox_achado = 1'b1;
                w_prox_tipo   = TIPO_W'(t);
            end
        end
        peca_d    = peca_q + 4'd1;
        tipo_d    = tipo_q;
        jogador_d = jogador_q;
        fim_d     = 1'b0;
        if ({1'b0, peca_q} + 5'd1 >= {1'b0, f_nibble(QTD_TIPO, int'(tipo_q))}) begin
            peca_d = 4'd0;
            if (w_prox_achado) begin
                tipo_d = w_prox_tipo;
            end else if (jogador_q == c_ULTIMO_JOG) begin
                fim_d = 1'b1;
            end else begin
                jogador_d = jogador_q + JOG_W'(1);
                tipo_d    = c_PRIMEIRO_TIPO;
            end
        end
    end

    // Placement FSM with registered outputs. The store strobe always self-clears after one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q     <= S_DIRECAO;
            tipo_q       <= c_PRIMEIRO_TIPO;
            jogador_q    <= '0;
            peca_q       <= 4'd0;
            x1_q         <= '0;
            y1_q         <= '0;
            direcao_q    <= 1'b0;
            orientacao_q <= 1'b0;
            valida_q     <= 1'b0;
            grava_q      <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            grava_q <= 1'b0;
            if (enable) begin
`ifdef AUTO_POS_EN
                if (mode && jogador_q == c_ULTIMO_JOG && estado_q != S_FIM) begin
                    case (estado_q)
                        S_VERIFICA: begin
                            valida_q <= valida_d;
                            estado_q <= valida_d ? S_ARMAZENA : S_DEF_X;
                        end
                        S_ARMAZENA: begin
                            grava_q      <= 1'b1;
                            valida_q     <= 1'b0;
                            x1_q         <= '0;
                            y1_q         <= '0;
                            direcao_q    <= 1'b0;
                            orientacao_q <= 1'b0;
                            peca_q       <= peca_d;
                            tipo_q       <= tipo_d;
                            jogador_q    <= jogador_d;
                            ready_q      <= fim_d;
                            estado_q     <= fim_d ? S_FIM : S_DIRECAO;
                        end
                        default: begin
                            x1_q         <= rnd_x;
                            y1_q         <= rnd_y;
                            direcao_q    <= rnd_dir;
                            orientacao_q <= 1'b0;
                            estado_q     <= S_VERIFICA;
                        end
                    endcase
                end else
`endif
                begin
                    case (estado_q)
                        S_DIRECAO: begin
                            if (w_ent)      estado_q  <= S_ORIENTACAO;
                            else if (w_sel) direcao_q <= ~direcao_q;
                        end
                        S_ORIENTACAO: begin
                            if (w_ent)      estado_q     <= S_DEF_X;
                            else if (w_sel) orientacao_q <= ~orientacao_q;
                        end
                        S_DEF_X: begin
                            if (w_ent)      estado_q <= S_DEF_Y;
                            else if (w_sel) x1_q     <= x1_q + COORD_W'(1);
                        end
                        S_DEF_Y: begin
                            if (w_ent)      estado_q <= S_VERIFICA;
                            else if (w_sel) y1_q     <= y1_q + COORD_W'(1);
                        end
                        S_VERIFICA: begin
                            valida_q <= valida_d;
                            if (w_ent) estado_q <= valida_q ? S_ARMAZENA : S_DEF_X;
                        end
                        S_ARMAZENA: begin
                            if (w_ent) begin
                                grava_q      <= 1'b1;
                                valida_q     <= 1'b0;
                                x1_q         <= '0;
                                y1_q         <= '0;
                                direcao_q    <= 1'b0;
                                orientacao_q <= 1'b0;
                                peca_q       <= peca_d;
                                tipo_q       <= tipo_d;
                                jogador_q    <= jogador_d;
                                ready_q      <= fim_d;
                                estado_q     <= fim_d ? S_FIM : S_DIRECAO;
                            end
                        end
                        S_FIM: begin
                            ready_q <= 1'b1;
                        end
                        default: begin
                            estado_q <= S_DIRECAO;
                        end
                    endcase
                end
            end
        end
    end

    assign tipo       = tipo_q;
    assign jogador    = jogador_q;
    assign X1         = x1_q;
    assign Y1         = y1_q;
    assign direcao    = direcao_q;
    assign orientacao = orientacao_q;
    assign valida     = valida_q;
    assign grava      = grava_q;
    assign ready      = ready_q;

endmodule

`default_nettype wire
